mult_sched: RTL and testbench

- Round-robin scheduler that shares one sequential 4x4 Booth multiplier (start/fin handshake, 8-bit product) between NREQ requesters.
- Arbitrates requests and latches the winner's operands.
- Sequences the multiplier through start -> fin, then returns the product to the owner with a one-cycle done pulse.
- Sits between client blocks and the single multiplier instance. Adds a watchdog so that a missing fin cannot hang the design.

---
 rtl/mult_sched_pkg.sv | 14 +
 rtl/mult_sched_if.sv | 32 +++
 rtl/mult_sched_rr_pick.sv | 38 +++
 rtl/mult_sched.sv | 124 ++++++++++++
 tb/tb_mult_sched.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mult_sched_pkg.sv
// Shared definitions for the multiplier scheduler: FSM state encoding and datapath widths.
package mult_pkg;

    localparam int OPW = 4;
    localparam int PRW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mult_sched_if.sv
// Client and multiplier signal bundle for mult_sched; slave is the scheduler's view.
interface mult_sched_if
    import mult_pkg::*;
#(
    parameter int NREQ = 4
);

    logic [NREQ-1:0]     req;
    logic [OPW*NREQ-1:0] opa;
    logic [OPW*NREQ-1:0] opb;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic [PRW-1:0]      res;
    logic                err;
    logic                busy;
    logic                m_start;
    logic [OPW-1:0]      m_multiplicando;
    logic [OPW-1:0]      m_multiplicador;
    logic                m_fin;
    logic [PRW-1:0]      m_producto;

    modport master (
        output req, opa, opb, m_fin, m_producto,
        input  gnt, done, res, err, busy, m_start, m_multiplicando, m_multiplicador
    );

    modport slave (
        input  req, opa, opb, m_fin, m_producto,
        output gnt, done, res, err, busy, m_start, m_multiplicando, m_multiplicador
    );

endinterface

// File: rtl/mult_sched_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from last+1 with wrap.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] winner,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [NREQ-1:0] rot;
    logic [IW-1:0]   pos [NREQ];

    // rot[gi] is the request gi+1 places after last, so rot[0] has top priority
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
            logic [IW:0] sum;
            assign sum     = {1'b0, last} + (IW+1)'(gi + 1);
            assign pos[gi] = IW'((sum >= (IW+1)'(NREQ)) ? (sum - (IW+1)'(NREQ)) : sum);
            assign rot[gi] = req[pos[gi]];
        end
    endgenerate

    always_comb begin
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx = pos[k];
            end
        end
    end

    assign any    = |req;
    assign winner = any ? ({{(NREQ-1){1'b0}}, 1'b1} << idx) : '0;

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one sequential Booth multiplier between NREQ clients,
// with a watchdog that aborts an operation whose fin never arrives.
module mult_sched
    import mult_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    mult_sched_if.slave  bus
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT) + 1;

    state_t          state_reg;
    logic [IW-1:0]   owner_reg;
    logic [IW-1:0]   last_reg;
    logic [NREQ-1:0] own_hot_reg;
    logic            armed_reg;
    logic [CW-1:0]   cnt_reg;
    logic [NREQ-1:0] gnt_reg;
    logic [NREQ-1:0] done_reg;
    logic [PRW-1:0]  res_reg;
    logic            err_reg;
    logic            busy_reg;
    logic            m_start_reg;
    logic [OPW-1:0]  mcand_reg;
    logic [OPW-1:0]  mplier_reg;

    logic [NREQ-1:0] pick_hot;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (bus.req),
        .last   (last_reg),
        .winner (pick_hot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            owner_reg   <= '0;
            last_reg    <= IW'(NREQ - 1);
            own_hot_reg <= '0;
            armed_reg   <= 1'b0;
            cnt_reg     <= '0;
            gnt_reg     <= '0;
            done_reg    <= '0;
            res_reg     <= '0;
            err_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            m_start_reg <= 1'b0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_any) begin
                        owner_reg   <= pick_idx;
                        own_hot_reg <= pick_hot;
                        mcand_reg   <= bus.opa[pick_idx*OPW +: OPW];
                        mplier_reg  <= bus.opb[pick_idx*OPW +: OPW];
                        gnt_reg     <= pick_hot;
                        m_start_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                        state_reg   <= ISSUE;
                    end
                end
                ISSUE: begin
                    gnt_reg     <= '0;
                    m_start_reg <= 1'b0;
                    // a fin still high from the previous op must drop before it counts
                    armed_reg   <= ~bus.m_fin;
                    cnt_reg     <= '0;
                    state_reg   <= WAIT;
                end
                WAIT: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (!armed_reg && !bus.m_fin) begin
                        armed_reg <= 1'b1;
                    end
                    if (armed_reg && bus.m_fin) begin
                        res_reg   <= bus.m_producto;
                        err_reg   <= 1'b0;
                        done_reg  <= own_hot_reg;
                        state_reg <= DONE;
                    end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                        res_reg   <= '0;
                        err_reg   <= 1'b1;
                        done_reg  <= own_hot_reg;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= '0;
                    res_reg   <= '0;
                    err_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                    last_reg  <= owner_reg;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.gnt             = gnt_reg;
    assign bus.done            = done_reg;
    assign bus.res             = res_reg;
    assign bus.err             = err_reg;
    assign bus.busy            = busy_reg;
    assign bus.m_start         = m_start_reg;
    assign bus.m_multiplicando = mcand_reg;
    assign bus.m_multiplicador = mplier_reg;

endmodule

// File: tb/tb_mult_sched.sv
// Directed bench for mult_sched with a behavioural multiplier whose fin timing is programmable.
module tb_mult_sched;

    logic clk = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    mult_sched_if #(.NREQ(4)) bus ();

    mult_sched #(
        .NREQ    (4),
        .TIMEOUT (32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // multiplier model: counts cycles from the start pulse, drops fin at drop_at, raises it at rise_at
    logic       fin_m  = 1'b0;
    logic [7:0] prod_m = 8'h00;
    logic [3:0] la = 4'h0, lb = 4'h0;
    bit         mact   = 1'b0;
    int         mcnt   = 0;
    int         drop_at = 2;
    int         rise_at = 8;

    assign bus.m_fin      = fin_m;
    assign bus.m_producto = prod_m;

    always @(posedge clk) begin
        if (bus.m_start) begin
            mact <= 1'b1;
            mcnt <= 2;
            la   <= bus.m_multiplicando;
            lb   <= bus.m_multiplicador;
        end else if (mact) begin
            if (mcnt == drop_at) fin_m <= 1'b0;
            if (mcnt == rise_at) begin
                fin_m  <= 1'b1;
                prod_m <= $signed(la) * $signed(lb);
                mact   <= 1'b0;
            end
            mcnt <= mcnt + 1;
        end
    end

    bit multi_gnt = 1'b0;
    always @(negedge clk) if ($countones(bus.gnt) > 1) multi_gnt <= 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0h", tag, got);
        end
    endtask

    task automatic set_ops(input int c, input logic [3:0] a, input logic [3:0] b);
        bus.opa[c*4 +: 4] = a;
        bus.opb[c*4 +: 4] = b;
    endtask

    task automatic wait_gnt(input string tag, input logic [3:0] exp_g, output int t);
        bit seen = 1'b0;
        logic [3:0] g;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus.gnt != 0) seen = 1'b1;
        end
        t = cyc;
        g = bus.gnt;
        check({tag, "_gnt"}, 32'(g), 32'(exp_g));
        if (seen) begin
            check({tag, "_mstart_busy"}, {bus.m_start, bus.busy}, 2'b11);
            bus.req = bus.req & ~g;
            @(negedge clk);
            check({tag, "_gnt_pulse"}, {bus.gnt, bus.m_start}, 0);
        end
    endtask

    task automatic wait_done(input string tag, input logic [3:0] exp_d, input logic [7:0] exp_r,
                             input logic exp_e, input int t_gnt, input int exp_lat);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus.done != 0) seen = 1'b1;
        end
        check({tag, "_done"}, 32'(bus.done), 32'(exp_d));
        if (seen) begin
            check({tag, "_res"}, 32'(bus.res), 32'(exp_r));
            check({tag, "_err"}, 32'(bus.err), 32'(exp_e));
            check({tag, "_lat"}, 32'(cyc - t_gnt), 32'(exp_lat));
            @(negedge clk);
            check({tag, "_after"}, {bus.done, bus.res, bus.err, bus.busy}, 0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bit done_seen;
        logic [7:0] exp_rr [4];
        exp_rr = '{8'h0F, 8'h0E, 8'hF1, 8'hC8};

        reset_n = 1'b0;
        bus.req = '0;
        bus.opa = '0;
        bus.opb = '0;
        repeat (2) @(negedge clk);
        check("reset_outs", {bus.gnt, bus.done, bus.res, bus.err, bus.busy, bus.m_start,
                             bus.m_multiplicando, bus.m_multiplicador}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // single op, client 0: 3*5
        set_ops(0, 4'h3, 4'h5);
        bus.req = 4'b0001;
        wait_gnt("single", 4'b0001, t);
        check("single_operands", {bus.m_multiplicando, bus.m_multiplicador}, 8'h35);
        wait_done("single", 4'b0001, 8'h0F, 1'b0, t, 9);

        // signed op, client 2: -3*5
        set_ops(2, 4'hD, 4'h5);
        bus.req = 4'b0100;
        wait_gnt("signed", 4'b0100, t);
        wait_done("signed", 4'b0100, 8'hF1, 1'b0, t, 9);

        // stale fin: fin still high from last op, drops 2 cycles after start, rises 6 later; 6*3
        set_ops(3, 4'h6, 4'h3);
        bus.req = 4'b1000;
        wait_gnt("stale", 4'b1000, t);
        wait_done("stale", 4'b1000, 8'h12, 1'b0, t, 9);

        // all four request together; operands scribbled after each grant must not matter
        set_ops(0, 4'h3, 4'h5);
        set_ops(1, 4'h2, 4'h7);
        set_ops(2, 4'hD, 4'h5);
        set_ops(3, 4'h7, 4'h8);
        bus.req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_gnt($sformatf("rr%0d", k), 4'(1 << k), t);
            set_ops(k, 4'h0, 4'h0);
            if (k == 3) begin
                set_ops(0, 4'h8, 4'h8);
                set_ops(2, 4'h6, 4'hF);
                bus.req = bus.req | 4'b0101;
            end
            wait_done($sformatf("rr%0d", k), 4'(1 << k), exp_rr[k], 1'b0, t, 9);
        end
        wait_gnt("rr_again0", 4'b0001, t);
        wait_done("rr_again0", 4'b0001, 8'h40, 1'b0, t, 9);
        wait_gnt("rr_again2", 4'b0100, t);
        wait_done("rr_again2", 4'b0100, 8'hFA, 1'b0, t, 9);

        // timeout: fin never rises
        rise_at = -1;
        set_ops(1, 4'h2, 4'h7);
        bus.req = 4'b0010;
        wait_gnt("tmo", 4'b0010, t);
        wait_done("tmo", 4'b0010, 8'h00, 1'b1, t, 33);
        rise_at = 8;
        bus.req = 4'b0010;
        wait_gnt("post_tmo", 4'b0010, t);
        wait_done("post_tmo", 4'b0010, 8'h0E, 1'b0, t, 9);

        // reset while client 3 is in WAIT
        set_ops(3, 4'h7, 4'h8);
        bus.req = 4'b1000;
        wait_gnt("abort", 4'b1000, t);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_outs", {bus.gnt, bus.done, bus.res, bus.err, bus.busy, bus.m_start,
                             bus.m_multiplicando, bus.m_multiplicador}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        done_seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done != 0) done_seen = 1'b1;
        end
        check("abort_no_done", 32'(done_seen), 0);

        // pointer back at NREQ-1: client 0 beats client 2
        set_ops(0, 4'h8, 4'h7);
        set_ops(2, 4'h6, 4'hF);
        bus.req = 4'b0101;
        wait_gnt("post_rst0", 4'b0001, t);
        wait_done("post_rst0", 4'b0001, 8'hC8, 1'b0, t, 9);
        wait_gnt("post_rst2", 4'b0100, t);
        wait_done("post_rst2", 4'b0100, 8'hFA, 1'b0, t, 9);

        check("gnt_onehot", 32'(multi_gnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
